// File: rtl/therm2bin_bubble_pipe_pkg.sv
// therm2bin_bubble_pipe_pkg: latency and per-stage window geometry for the thermometer converter
package therm2bin_bubble_pipe_pkg;
    function automatic int lat(input int b, input int f);
        return b - f + 2;
    endfunction
    function automatic int stage_w(input int b, input int s);
        return (1 << (b - s)) - 1;
    endfunction
    function automatic int stage_mid(input int b, input int s);
        return (1 << (b - s - 1)) - 1;
    endfunction
endpackage

// File: rtl/therm2bin_bubble_pipe_if.sv
// therm2bin_bubble_pipe_if: sample-in / code-out bundle of the thermometer converter
interface therm2bin_bubble_pipe_if #(
    parameter int B     = 8,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic [2**B-1:0]   thermo;
    logic              clear_cnt;
    logic              out_valid;
    logic [B-1:0]      bin;
    logic              overflow;
    logic              bubble_err;
    logic [CNT_W-1:0]  bubble_count;
    modport master (output in_valid, thermo, clear_cnt, input out_valid, bin, overflow, bubble_err, bubble_count);
    modport slave  (input in_valid, thermo, clear_cnt, output out_valid, bin, overflow, bubble_err, bubble_count);
endinterface

// File: rtl/count_ones.sv
// count_ones: combinational population count
module count_ones #(
    parameter int W  = 15,
    parameter int OW = 4
) (
    input  logic [W-1:0]  d,
    output logic [OW-1:0] n
);
    always_comb begin
        n = '0;
        for (int i = 0; i < W; i++) n = n + OW'(d[i]);
    end
endmodule

// File: rtl/therm2bin_bubble_pipe_bubble_fix.sv
// therm_bubble_fix: 3-input majority filter over a thermometer word, flagging any altered bit
module therm_bubble_fix #(
    parameter int N = 256
) (
    input  logic [N-1:0] t,
    output logic [N-1:0] c,
    output logic         err
);
    logic [N+1:0] e;
    always_comb begin
        e = {1'b0, t, 1'b1};
        c = '0;
        for (int k = 0; k < N; k++) c[k] = (e[k] & e[k+1]) | (e[k] & e[k+2]) | (e[k+1] & e[k+2]);
        err = c != t;
    end
endmodule

// File: rtl/therm2bin_bubble_pipe.sv
// therm2bin_bubble_pipe: bubble-corrected thermometer-to-binary pipeline
// (majority stage, B-F binary-search stages, popcount tail, saturating bubble counter)
module therm2bin_bubble_pipe
    import therm2bin_bubble_pipe_pkg::*;
#(
    parameter int B     = 8,
    parameter int F     = 4,
    parameter int CNT_W = 16
) (
    input logic                    clock,
    input logic                    reset,
    therm2bin_bubble_pipe_if.slave bus
);
    localparam int N = 2 ** B;
    localparam int S = B - F;
    logic [N-1:0]     c_d, c_q;
    logic             cv_d, cv_q, ce_d, ce_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    therm_bubble_fix #(.N(N)) u_fix (.t(bus.thermo), .c(c_d), .err(ce_d));
    // clear beats a coincident count event
    always_comb begin
        cv_d  = bus.in_valid;
        cnt_d = bus.clear_cnt ? '0 : (cv_q && ce_q && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) {c_q, cv_q, ce_q, cnt_q} <= '0;
        else {c_q, cv_q, ce_q, cnt_q} <= {c_d, cv_d, ce_d, cnt_d};
    assign bus.bubble_count = cnt_q;
    genvar s;
    for (s = 0; s < S; s++) begin : g_srch
        localparam int W = stage_w(B, s);
        localparam int M = stage_mid(B, s);
        logic [W-1:0] din;
        logic [s:0]   b_d, b_q;
        logic [M-1:0] d_d, d_q;
        logic         v_d, v_q, o_d, o_q, e_d, e_q;
        if (s == 0) begin : g_in
            always_comb begin
                din = c_q[N-2:0];
                b_d = din[M];
                {v_d, o_d, e_d} = {cv_q, c_q[N-1], ce_q};
            end
        end else begin : g_in
            always_comb begin
                din = g_srch[s-1].d_q;
                b_d = {g_srch[s-1].b_q, din[M]};
                {v_d, o_d, e_d} = {g_srch[s-1].v_q, g_srch[s-1].o_q, g_srch[s-1].e_q};
            end
        end
        // keep the half of the window that still holds the 1->0 transition
        always_comb d_d = din[M] ? din[W-1:M+1] : din[M-1:0];
        always_ff @(posedge clock or posedge reset)
            if (reset) {d_q, b_q, v_q, o_q, e_q} <= '0;
            else {d_q, b_q, v_q, o_q, e_q} <= {d_d, b_d, v_d, o_d, e_d};
    end
    logic [F-1:0] pop;
    logic         out_valid_d, out_valid_q, overflow_d, overflow_q, bubble_err_d, bubble_err_q;
    logic [B-1:0] bin_d, bin_q;
    count_ones #(.W(2 ** F - 1), .OW(F)) u_pop (.d(g_srch[S-1].d_q), .n(pop));
    always_comb begin
        out_valid_d  = g_srch[S-1].v_q;
        overflow_d   = out_valid_d & g_srch[S-1].o_q;
        bubble_err_d = out_valid_d & g_srch[S-1].e_q;
        bin_d        = !out_valid_d ? '0 : overflow_d ? '1 : {g_srch[S-1].b_q, pop};
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) {out_valid_q, overflow_q, bubble_err_q, bin_q} <= '0;
        else {out_valid_q, overflow_q, bubble_err_q, bin_q} <= {out_valid_d, overflow_d, bubble_err_d, bin_d};
    assign bus.out_valid  = out_valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.bubble_err = bubble_err_q;
    assign bus.bin        = bin_q;
endmodule

// File: tb/tb_therm2bin_bubble_pipe.sv
// tb_therm2bin_bubble_pipe: three converters (F=4,1,7) driven in parallel against a behavioural model
module tb_therm2bin_bubble_pipe;
    localparam int B    = 8;
    localparam int N    = 2 ** B;
    localparam int NI   = 3;
    localparam int MAXC = 4096;
    logic clock = 1'b0;
    logic reset, in_valid, clear_cnt;
    logic [N-1:0] thermo;
    int checks = 0, errors = 0, cyc = 0, floor_cyc = 0;
    int fq [NI]   = '{4, 1, 7};
    int lq [NI]   = '{6, 9, 3};
    int cmax [NI] = '{65535, 15, 65535};
    int mcnt [NI] = '{0, 0, 0};
    logic [N-1:0] rec_t [MAXC];
    logic rec_v [MAXC];
    logic rec_c [MAXC];
    logic ov [NI];
    logic oo [NI];
    logic oe [NI];
    logic [B-1:0] ob [NI];
    logic [15:0] oc [NI];

    always #5 clock = ~clock;

    therm2bin_bubble_pipe_if #(.B(B), .CNT_W(16)) if0 ();
    therm2bin_bubble_pipe_if #(.B(B), .CNT_W(4))  if1 ();
    therm2bin_bubble_pipe_if #(.B(B), .CNT_W(16)) if2 ();
    assign {if0.in_valid, if1.in_valid, if2.in_valid} = {3{in_valid}};
    assign {if0.clear_cnt, if1.clear_cnt, if2.clear_cnt} = {3{clear_cnt}};
    assign if0.thermo = thermo;
    assign if1.thermo = thermo;
    assign if2.thermo = thermo;
    therm2bin_bubble_pipe #(.B(B), .F(4), .CNT_W(16)) dut0 (.clock(clock), .reset(reset), .bus(if0.slave));
    therm2bin_bubble_pipe #(.B(B), .F(1), .CNT_W(4))  dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
    therm2bin_bubble_pipe #(.B(B), .F(7), .CNT_W(16)) dut2 (.clock(clock), .reset(reset), .bus(if2.slave));
    assign ov[0] = if0.out_valid;  assign ov[1] = if1.out_valid;  assign ov[2] = if2.out_valid;
    assign oo[0] = if0.overflow;   assign oo[1] = if1.overflow;   assign oo[2] = if2.overflow;
    assign oe[0] = if0.bubble_err; assign oe[1] = if1.bubble_err; assign oe[2] = if2.bubble_err;
    assign ob[0] = if0.bin;        assign ob[1] = if1.bin;        assign ob[2] = if2.bin;
    assign oc[0] = if0.bubble_count;
    assign oc[1] = 16'(if1.bubble_count);
    assign oc[2] = if2.bubble_count;

    function automatic logic [N-1:0] mono(input int level);
        logic [N-1:0] v = '0;
        for (int i = 0; i < level; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] ref_fix(input logic [N-1:0] t);
        logic [N-1:0] c = '0;
        for (int k = 0; k < N; k++) begin
            int up = (k == 0) ? 1 : int'(t[k-1]);
            int dn = (k == N - 1) ? 0 : int'(t[k+1]);
            c[k] = (up + int'(t[k]) + dn) >= 2;
        end
        return c;
    endfunction

    function automatic int ref_bin(input logic [N-1:0] t, input int f);
        logic [N-1:0] c = ref_fix(t);
        int lo = 0, w = N - 1, code = 0, pop = 0;
        if (c[N-1]) return N - 1;
        for (int s = 0; s < B - f; s++) begin
            int m = lo + w / 2;
            code = code * 2 + int'(c[m]);
            if (c[m]) lo = m + 1;
            w = w / 2;
        end
        for (int i = lo; i < lo + w; i++) pop += int'(c[i]);
        return code * (1 << f) + pop;
    endfunction

    task automatic step();
        rec_v[cyc] = in_valid;
        rec_t[cyc] = thermo;
        rec_c[cyc] = clear_cnt;
        @(posedge clock);
        #1;
        cyc++;
        if (reset) floor_cyc = cyc;
        for (int i = 0; i < NI; i++) begin
            if (reset || rec_c[cyc-1]) mcnt[i] = 0;
            else if (cyc >= 2 && cyc - 2 >= floor_cyc && rec_v[cyc-2] &&
                     ref_fix(rec_t[cyc-2]) != rec_t[cyc-2] && mcnt[i] < cmax[i]) mcnt[i]++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({ov[i], oo[i], oe[i], ob[i], oc[i]} !== '0) begin
                errors++;
                $display("FAIL reset dut%0d got v=%b o=%b e=%b bin=%0d cnt=%0d, want all 0", i, ov[i], oo[i], oe[i], ob[i], oc[i]);
            end
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] tv [6];
        int   eb [6] = '{100, 100, 100, 255, 0, 255};
        logic eo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic ee [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int c0;
        tv[0] = mono(100);
        tv[1] = mono(100); tv[1][50] = 1'b0;
        tv[2] = mono(100); tv[2][120] = 1'b1;
        tv[3] = mono(256);
        tv[4] = '0;
        tv[5] = mono(255);
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        c0 = cyc;
        for (int j = 0; j < 24; j++) begin
            in_valid = (j < 12) && (j % 2 == 0);
            thermo = in_valid ? tv[j/2] : '0;
            step();
            for (int i = 0; i < NI; i++) begin
                int off = cyc - c0 - lq[i];
                logic hit = off >= 0 && off < 12 && off % 2 == 0;
                int p = hit ? off / 2 : 0;
                logic [B-1:0] xb = hit ? B'(eb[p]) : '0;
                logic xo = hit & eo[p];
                logic xe = hit & ee[p];
                checks++;
                if (ov[i] !== hit || ob[i] !== xb || oo[i] !== xo || oe[i] !== xe) begin
                    errors++;
                    $display("FAIL directed dut%0d off=%0d got v=%b bin=%0d o=%b e=%b, want v=%b bin=%0d o=%b e=%b",
                             i, off, ov[i], ob[i], oo[i], oe[i], hit, xb, xo, xe);
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (oc[i] !== 16'd2) begin
                errors++;
                $display("FAIL directed_count dut%0d got %0d want 2", i, oc[i]);
            end
        end
    endtask

    task automatic test_stream(input int nc);
        for (int j = 0; j < nc + 12; j++) begin
            int flip = $urandom_range(0, N - 1);
            in_valid = j < nc && $urandom_range(0, 3) != 0;
            thermo = mono($urandom_range(0, N));
            if ($urandom_range(0, 7) == 0) thermo[flip] = ~thermo[flip];
            clear_cnt = $urandom_range(0, 31) == 0;
            step();
            for (int i = 0; i < NI; i++) begin
                int k = cyc - lq[i];
                logic ev = k >= floor_cyc && rec_v[k];
                logic [N-1:0] c = ref_fix(rec_t[k]);
                logic [B-1:0] xb = ev ? B'(ref_bin(rec_t[k], fq[i])) : '0;
                logic xo = ev & c[N-1];
                logic xe = ev && c != rec_t[k];
                checks++;
                if (ov[i] !== ev || ob[i] !== xb || oo[i] !== xo || oe[i] !== xe) begin
                    errors++;
                    $display("FAIL stream dut%0d cyc=%0d got v=%b bin=%0d o=%b e=%b, want v=%b bin=%0d o=%b e=%b",
                             i, cyc, ov[i], ob[i], oo[i], oe[i], ev, xb, xo, xe);
                end
                checks++;
                if (oc[i] !== 16'(mcnt[i])) begin
                    errors++;
                    $display("FAIL stream_count dut%0d cyc=%0d got %0d want %0d", i, cyc, oc[i], mcnt[i]);
                end
            end
        end
        clear_cnt = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        clear_cnt = 1'b1;
        in_valid = 1'b0;
        step();
        clear_cnt = 1'b0;
        for (int j = 0; j < 20; j++) begin
            in_valid = 1'b1;
            thermo = mono(60);
            thermo[30] = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            logic [15:0] x = (i == 1) ? 16'd15 : 16'd20;
            checks++;
            if (oc[i] !== x) begin
                errors++;
                $display("FAIL saturation dut%0d got %0d want %0d", i, oc[i], x);
            end
        end
    endtask

    task automatic test_clear_collision();
        in_valid = 1'b1;
        thermo = mono(60);
        thermo[30] = 1'b0;
        step();
        in_valid = 1'b0;
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (oc[i] !== 16'd0) begin
                    errors++;
                    $display("FAIL clear_collision dut%0d t+%0d got %0d want 0", i, j, oc[i]);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_inflight();
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            thermo = mono($urandom_range(1, N - 1));
            step();
        end
        reset = 1'b1;
        #1;
        test_reset();
        in_valid = 1'b0;
        thermo = '0;
        step();
        reset = 1'b0;
        in_valid = 1'b1;
        thermo = mono(37);
        step();
        in_valid = 1'b0;
        thermo = '0;
        for (int j = 1; j <= 10; j++) begin
            for (int i = 0; i < NI; i++) begin
                logic hit = j == lq[i];
                logic [B-1:0] xb = hit ? 8'd37 : 8'd0;
                checks++;
                if (ov[i] !== hit || ob[i] !== xb) begin
                    errors++;
                    $display("FAIL reset_inflight dut%0d t+%0d got v=%b bin=%0d, want v=%b bin=%0d", i, j, ov[i], ob[i], hit, xb);
                end
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        clear_cnt = 1'b0;
        thermo = '0;
        step();
        step();
        test_reset();
        reset = 1'b0;
        step();
        test_reset();
        test_directed();
        test_stream(300);
        test_saturation();
        test_clear_collision();
        test_reset_inflight();
        test_stream(60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
